// File: rtl/sound_pkg.sv
// Shared types, field positions and arithmetic helpers for the sound mixer
// and any other audio block that reuses its sigma-delta stage.
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        COMMIT = 2'd2
    } mix_state_e;

    localparam int LEVEL_W     = 8;
    localparam int GAIN_W      = 6;
    localparam int CFG_W       = 8;
    localparam int CFG_EN_BIT  = 7;
    localparam int CFG_VOL_MSB = 5;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

    // Add a gain onto the running sum, clamping at full scale instead of wrapping.
    function automatic logic [LEVEL_W-1:0] sat_add(input logic [LEVEL_W-1:0] acc,
                                                   input logic [GAIN_W-1:0]  gain);
        logic [LEVEL_W:0] sum;
        sum = {1'b0, acc} + {{(LEVEL_W + 1 - GAIN_W){1'b0}}, gain};
        return sum[LEVEL_W] ? LEVEL_MAX : sum[LEVEL_W-1:0];
    endfunction

    function automatic logic [GAIN_W-1:0] cfg_target(input logic [CFG_W-1:0] cfg);
        return cfg[CFG_EN_BIT] ? cfg[CFG_VOL_MSB:0] : '0;
    endfunction

    function automatic logic [GAIN_W-1:0] ramp_step(input logic [GAIN_W-1:0] gain,
                                                    input logic [GAIN_W-1:0] target);
        logic [GAIN_W-1:0] next_gain;
        next_gain = gain;
        if (gain < target) begin
            next_gain = gain + 1'b1;
        end else if (gain > target) begin
            next_gain = gain - 1'b1;
        end
        return next_gain;
    endfunction

endpackage

// File: rtl/sound_mixer_if.sv
// Configuration bus of the sound mixer: per-source enable/volume writes and
// registered readback.
interface sound_mixer_if;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;

    modport master (
        output cfg_we,
        output cfg_addr,
        output cfg_wdata,
        input  cfg_rdata
    );

    modport slave (
        input  cfg_we,
        input  cfg_addr,
        input  cfg_wdata,
        output cfg_rdata
    );
endinterface

// File: rtl/sound_sigma_delta.sv
// First-order sigma-delta modulator: the carry of a free-running level
// accumulator is the 1-bit PWM output, so its duty over 256 clocks equals level.
module sound_sigma_delta
    import sound_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [LEVEL_W-1:0] level,
    output logic               o_pwm
);

    logic [LEVEL_W:0] pacc_q;
    logic [LEVEL_W:0] pacc_d;

    always_comb begin
        pacc_d = {1'b0, pacc_q[LEVEL_W-1:0]} + {1'b0, level};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pacc_q <= '0;
        end else begin
            pacc_q <= pacc_d;
        end
    end

    assign o_pwm = pacc_q[LEVEL_W];

endmodule

// File: rtl/sound_mixer.sv
// Time-shared mixer: snapshots NUM_SRC 1-bit sources once per sample period, sums
// them one per clock through a saturating adder with ramped gains, then drives PWM.
//
// state  | meaning
// IDLE   | waiting for the sample tick; snapshot sources and clear the sum on it
// ACCUM  | adding gain[idx] for each active snapshot bit, one source per clock
// COMMIT | publish the sum as level; every RAMP_DIV periods step gains toward target
module sound_mixer
    import sound_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int SAMPLE_DIV  = 512,
    parameter int RAMP_DIV    = 64,
    parameter int DEFAULT_VOL = 63
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] src_in,
    sound_mixer_if.slave       cfg,
    output logic [LEVEL_W-1:0] level,
    output logic               busy,
    output logic               o_pwm
);

    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int IDX_W  = $clog2(NUM_SRC);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_SRC - 1);
    localparam logic [CFG_W-1:0]  CFG_RESET = {1'b1, 1'b0, GAIN_W'(DEFAULT_VOL)};

    mix_state_e          state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [RAMP_W-1:0]   ramp_q, ramp_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_SRC-1:0]  snap_q, snap_d;
    logic [LEVEL_W-1:0]  acc_q, acc_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [CFG_W-1:0]    rdata_q, rdata_d;
    logic [GAIN_W-1:0]   gain_q [NUM_SRC];
    logic [GAIN_W-1:0]   gain_d [NUM_SRC];
    logic [CFG_W-1:0]    cfg_q  [NUM_SRC];
    logic [CFG_W-1:0]    cfg_d  [NUM_SRC];

    logic                tick;
    logic                addr_ok;
    logic [IDX_W-1:0]    cfg_idx;
    logic                unused_wdata;

    assign unused_wdata = cfg.cfg_wdata[6];

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        level_d = level_q;
        ramp_d  = ramp_q;
        gain_d  = gain_q;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    snap_d  = src_in;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (snap_q[idx_q]) begin
                    acc_d = sat_add(acc_q, gain_q[idx_q]);
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                level_d = acc_q;
                // Gains use the targets as registered before this edge, so a
                // write landing on the same clock only affects the next step.
                if (ramp_q == RAMP_LAST) begin
                    ramp_d = '0;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        gain_d[i] = ramp_step(gain_q[i], cfg_target(cfg_q[i]));
                    end
                end else begin
                    ramp_d = ramp_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        addr_ok = (int'(cfg.cfg_addr) < NUM_SRC);
        cfg_idx = cfg.cfg_addr[IDX_W-1:0];
        cfg_d   = cfg_q;
        rdata_d = '0;
        if (addr_ok) begin
            rdata_d = cfg_q[cfg_idx];
            if (cfg.cfg_we) begin
                cfg_d[cfg_idx] = {cfg.cfg_wdata[CFG_EN_BIT], 1'b0,
                                  cfg.cfg_wdata[CFG_VOL_MSB:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            ramp_q  <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            acc_q   <= '0;
            level_q <= '0;
            rdata_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                gain_q[i] <= '0;
                cfg_q[i]  <= CFG_RESET;
            end
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            ramp_q  <= ramp_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            acc_q   <= acc_d;
            level_q <= level_d;
            rdata_q <= rdata_d;
            gain_q  <= gain_d;
            cfg_q   <= cfg_d;
        end
    end

    sound_sigma_delta u_sigma_delta (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (level_q),
        .o_pwm   (o_pwm)
    );

    assign level         = level_q;
    assign busy          = (state_q == ACCUM);
    assign cfg.cfg_rdata = rdata_q;

endmodule

// File: tb/tb_sound_mixer.sv
// Bench for sound_mixer: per-period reference model of gains, targets and the
// saturating mix, plus duty-cycle checks on the sigma-delta stage.
module tb_sound_mixer;
    import sound_pkg::*;

    localparam int NA = 4;
    localparam int NB = 8;
    localparam int SD = 16;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NA-1:0] src_a;
    logic [NB-1:0] src_b;
    logic [7:0]    level_a, level_b, sd_level;
    logic          busy_a, busy_b, pwm_a, pwm_b, sd_pwm;

    sound_mixer_if if_a ();
    sound_mixer_if if_b ();

    sound_mixer #(.NUM_SRC(NA), .SAMPLE_DIV(SD), .RAMP_DIV(RD), .DEFAULT_VOL(63)) dut_a (
        .clk(clk), .reset_n(reset_n), .src_in(src_a), .cfg(if_a),
        .level(level_a), .busy(busy_a), .o_pwm(pwm_a)
    );

    sound_mixer #(.NUM_SRC(NB), .SAMPLE_DIV(SD), .RAMP_DIV(1), .DEFAULT_VOL(63)) dut_b (
        .clk(clk), .reset_n(reset_n), .src_in(src_b), .cfg(if_b),
        .level(level_b), .busy(busy_b), .o_pwm(pwm_b)
    );

    sound_sigma_delta u_sd (
        .clk(clk), .reset_n(reset_n), .level(sd_level), .o_pwm(sd_pwm)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pwm_ones = 0;
    int m_gain [NA];
    int m_reg  [NA];
    int m_pc;
    int m_gb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (pwm_a) pwm_ones++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NA; i++) begin
            m_gain[i] = 0;
            m_reg[i]  = 128 + 63;
        end
        m_pc = 0;
        m_gb = 0;
    endtask

    task automatic model_write(input int a, input int d);
        if (a < NA) m_reg[a] = d & 8'hBF;
    endtask

    task automatic model_commit();
        int t;
        m_pc++;
        if (m_pc % RD == 0) begin
            for (int i = 0; i < NA; i++) begin
                t = (m_reg[i] >= 128) ? (m_reg[i] % 64) : 0;
                if (m_gain[i] < t) m_gain[i]++;
                else if (m_gain[i] > t) m_gain[i]--;
            end
        end
    endtask

    function automatic int mix_sum(input logic [NA-1:0] pat);
        int s;
        s = 0;
        for (int i = 0; i < NA; i++) if (pat[i]) s += m_gain[i];
        return (s > 255) ? 255 : s;
    endfunction

    task automatic cfg_write(input int a, input int d);
        if_a.cfg_we    = 1'b1;
        if_a.cfg_addr  = 3'(a);
        if_a.cfg_wdata = 8'(d);
    endtask

    // Starts at the negedge before a snapshot edge and ends one period later.
    // mode: 0 no write, 1 write during ACCUM, 2 write during COMMIT.
    task automatic run_period(input logic [NA-1:0] pat, input int mode, input int wa,
                              input int wd, input int rd_sel);
        int exp_a, exp_b, ra;
        src_a = pat;
        step(1);
        chk("busy_first", busy_a, 1);
        exp_a = mix_sum(pat);
        src_a = NA'($urandom);
        if (mode == 1) cfg_write(wa, wd);
        step(1);
        if_a.cfg_we = 1'b0;
        if (mode == 1) model_write(wa, wd);
        step(NA - 2);
        chk("busy_last", busy_a, 1);
        step(1);
        chk("busy_commit", busy_a, 0);
        if (mode == 2) cfg_write(wa, wd);
        step(1);
        if_a.cfg_we = 1'b0;
        chk("level_a", level_a, exp_a);
        model_commit();
        if (mode == 2) model_write(wa, wd);
        ra = (rd_sel > 7) ? int'($urandom_range(0, 7)) : rd_sel;
        if_a.cfg_addr = 3'(ra);
        step(1);
        chk("rdata", if_a.cfg_rdata, (ra < NA) ? m_reg[ra] : 0);
        step(SD - NA - 3);
        exp_b = (8 * m_gb > 255) ? 255 : 8 * m_gb;
        chk("level_b_sat", level_b, exp_b);
        if (m_gb < 63) m_gb++;
    endtask

    initial begin
        int prev, mono_bad, early, ones, bad;
        logic p;
        int lv [5];

        src_a = '0;
        src_b = '1;
        sd_level = '0;
        if_a.cfg_we = 1'b0; if_a.cfg_addr = '0; if_a.cfg_wdata = '0;
        if_b.cfg_we = 1'b0; if_b.cfg_addr = '0; if_b.cfg_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_level", level_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_pwm", pwm_a, 0);
        chk("rst_rdata", if_a.cfg_rdata, 0);
        chk("rst_level_b", level_b, 0);
        reset_n = 1'b1;
        model_reset();
        step(SD - 1);

        // Single source, full default ramp from zero gain.
        for (int p_i = 0; p_i < 63 * RD + 1; p_i++) run_period(4'b0001, 0, 0, 0, 8);
        chk("ramp_done", level_a, 63);

        // All four sources at full gain; duty of the mixer PWM over 256 clocks.
        run_period(4'b1111, 0, 0, 0, 8);
        run_period(4'b1111, 0, 0, 0, 8);
        pwm_ones = 0;
        for (int p_i = 0; p_i < 16; p_i++) run_period(4'b1111, 0, 0, 0, 8);
        chk("pwm_a_duty", pwm_ones, 252);

        // Disable source 2 mid-ACCUM and watch it ramp down.
        prev = level_a;
        mono_bad = 0;
        for (int p_i = 0; p_i < 256; p_i++) begin
            run_period(4'b1111, (p_i == 0) ? 1 : 0, 2, 8'h00, 2);
            if (level_a > prev) mono_bad++;
            prev = level_a;
        end
        chk("monotonic", mono_bad, 0);
        chk("level_floor", level_a, 189);

        // Re-enable source 2 with the write landing on a ramp-step COMMIT.
        while ((m_pc + 1) % RD != 0) run_period(4'b1111, 0, 0, 0, 8);
        run_period(4'b1111, 2, 2, 8'hBF, 2);
        for (int p_i = 0; p_i < 2 * RD + 1; p_i++) run_period(4'b1111, 0, 0, 0, 8);

        // Random sources, writes (including invalid addresses) and readbacks.
        for (int p_i = 0; p_i < 150; p_i++) begin
            run_period(NA'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 255)), 8);
        end

        // Asynchronous reset in the middle of ACCUM.
        src_a = 4'hF;
        step(2);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", busy_a, 0);
        chk("midrst_level", level_a, 0);
        chk("midrst_pwm", pwm_a, 0);
        chk("midrst_rdata", if_a.cfg_rdata, 0);
        chk("midrst_level_b", level_b, 0);
        chk("midrst_busy_b", busy_b, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        early = 0;
        for (int i = 0; i < SD - 1; i++) begin
            step(1);
            if (busy_a) early++;
        end
        chk("midrst_wait_tick", early, 0);
        for (int p_i = 0; p_i < 2 * RD + 2; p_i++) run_period(4'hF, 0, 0, 0, 8);

        // Sigma-delta stage driven directly.
        lv[0] = 0; lv[1] = 255; lv[2] = 128;
        lv[3] = int'($urandom_range(1, 254));
        lv[4] = int'($urandom_range(1, 254));
        for (int k = 0; k < 5; k++) begin
            sd_level = 8'(lv[k]);
            step(2);
            ones = 0;
            for (int i = 0; i < 256; i++) begin
                @(negedge clk);
                if (sd_pwm) ones++;
            end
            chk("sd_duty", ones, lv[k]);
            if (lv[k] == 128) begin
                bad = 0;
                p = sd_pwm;
                for (int i = 0; i < 16; i++) begin
                    @(negedge clk);
                    if (sd_pwm == p) bad++;
                    p = sd_pwm;
                end
                chk("sd_alternate", bad, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
